// File: rtl/live_sample_sequencer.sv
// LIVE-gated snapshot RAM write sequencer: holdoff, periodic write strobes,
// one-shot or circular addressing, and sticky status for register readback.
module live_sample_sequencer #(
    parameter int ADDR_W  = 12,
    parameter int TIMER_W = 17,
    parameter int HOLD_W  = 16,
    parameter int CNT_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LIVE,
    input  logic [TIMER_W-1:0] interval,
    input  logic [ADDR_W-1:0]  max,
    input  logic [HOLD_W-1:0]  holdoff,
    input  logic               circular,
    output logic               wr_ena,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               busy,
    output logic               done,
    output logic               wrapped,
    output logic [CNT_W-1:0]   wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               live_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] ilast_q;
    logic [HOLD_W-1:0]  hcnt_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [ADDR_W-1:0]  alast_q;
    logic [ADDR_W-1:0]  nxt_q;
    logic               circ_q;

    logic rise, tick_end, hold_end, issue, last_wr;

    // alast_q = max-1 at ADDR_W bits, so max=0 naturally yields the full depth
    always_comb begin
        rise     = LIVE & ~live_d;
        tick_end = (timer_q == ilast_q);
        hold_end = (hcnt_q == hold_q - HOLD_W'(1));
        issue    = (state_q == S_RUN) && LIVE && tick_end;
        last_wr  = (nxt_q == alast_q);
    end

    always_comb begin
        state_d = state_q;
        if (!LIVE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (rise) state_d = (holdoff != '0) ? S_HOLD : S_RUN;
                S_HOLD: if (hold_end) state_d = S_RUN;
                S_RUN:  if (issue && last_wr && !circ_q) state_d = S_DONE;
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            live_d  <= 1'b1;
        end else begin
            state_q <= state_d;
            live_d  <= LIVE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q  <= '0;
            timer_q <= '0;
        end else begin
            hcnt_q  <= (state_q == S_HOLD && state_d == S_HOLD) ? hcnt_q + HOLD_W'(1) : '0;
            if (state_q == S_RUN && state_d == S_RUN)
                timer_q <= tick_end ? '0 : timer_q + TIMER_W'(1);
            else
                timer_q <= '0;
        end
    end

    // run configuration is frozen on the LIVE rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ilast_q <= '0;
            hold_q  <= '0;
            alast_q <= '0;
            circ_q  <= 1'b0;
        end else if (rise) begin
            ilast_q <= (interval == '0) ? '0 : interval - TIMER_W'(1);
            hold_q  <= holdoff;
            alast_q <= max - ADDR_W'(1);
            circ_q  <= circular;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ena   <= 1'b0;
            wr_addr  <= '0;
            nxt_q    <= '0;
            done     <= 1'b0;
            wrapped  <= 1'b0;
            wr_count <= '0;
        end else begin
            wr_ena <= issue;
            if (!LIVE || rise) begin
                wr_addr <= '0;
                nxt_q   <= '0;
            end else if (issue) begin
                wr_addr <= nxt_q;
                nxt_q   <= last_wr ? '0 : nxt_q + ADDR_W'(1);
            end
            if (rise) begin
                done     <= 1'b0;
                wrapped  <= 1'b0;
                wr_count <= '0;
            end else if (issue) begin
                if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
                if (last_wr && !circ_q) done <= 1'b1;
                // address 0 after at least one earlier write means we came round
                if (circ_q && nxt_q == '0 && wr_count != '0) wrapped <= 1'b1;
            end
        end
    end

    assign busy = (state_q == S_HOLD) || (state_q == S_RUN);

endmodule

// File: tb/tb_live_sample_sequencer.sv
// Scoreboard bench for live_sample_sequencer: expected strobes are derived in
// closed form from the run parameters and matched against each wr_ena pulse.
module tb_live_sample_sequencer;

    localparam int AW = 4;
    localparam int TW = 17;
    localparam int HW = 16;
    localparam int CW = 3;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          LIVE;
    logic [TW-1:0] interval;
    logic [AW-1:0] max;
    logic [HW-1:0] holdoff;
    logic          circular;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [CW-1:0] wr_count;

    typedef struct {
        int addr;
        int cyc;
        int wrp;
        int dn;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc;
    int   n_chk;
    int   n_pass;

    live_sample_sequencer #(.ADDR_W(AW), .TIMER_W(TW), .HOLD_W(HW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .LIVE(LIVE), .interval(interval), .max(max),
        .holdoff(holdoff), .circular(circular), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .busy(busy), .done(done), .wrapped(wrapped), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    // write k issues on edge E(h+I*k) if LIVE is still sampled high there
    task automatic push_exp(input int c0, input int h, input int iv, input int m,
                            input bit circ, input int live_len);
        int i_eff, m_eff;
        exp_t e;
        i_eff = (iv == 0) ? 1 : iv;
        m_eff = (m == 0) ? DEPTH : m;
        for (int k = 1; k < 1000; k++) begin
            if (h + i_eff * k > live_len - 1) break;
            if (!circ && k > m_eff) break;
            e.addr = (k - 1) % m_eff;
            e.cyc  = c0 + h + i_eff * k;
            e.wrp  = (circ && k > m_eff) ? 1 : 0;
            e.dn   = (!circ && k == m_eff) ? 1 : 0;
            e.cnt  = (k > CMAX) ? CMAX : k;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (wr_ena === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_wr", int'(wr_ena), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_cycle", cyc, mon_e.cyc);
                chk("wr_addr", int'(wr_addr), mon_e.addr);
                chk("wr_wrapped", int'(wrapped), mon_e.wrp);
                chk("wr_done", int'(done), mon_e.dn);
                chk("wr_count", int'(wr_count), mon_e.cnt);
            end
        end
    end

    task automatic run(input int h, input int iv, input int m, input bit circ, input int live_len);
        int c0, m_eff, i_eff, nw, exp_done, exp_wrp, exp_cnt;
        i_eff = (iv == 0) ? 1 : iv;
        m_eff = (m == 0) ? DEPTH : m;
        nw = 0;
        for (int k = 1; k < 1000; k++) begin
            if (h + i_eff * k > live_len - 1) break;
            if (!circ && k > m_eff) break;
            nw = k;
        end
        exp_done = (!circ && nw == m_eff) ? 1 : 0;
        exp_wrp  = (circ && nw > m_eff) ? 1 : 0;
        exp_cnt  = (nw > CMAX) ? CMAX : nw;

        @(negedge clk);
        holdoff  = HW'(h);
        interval = TW'(iv);
        max      = AW'(m);
        circular = circ;
        LIVE     = 1'b1;
        c0 = cyc + 1;
        push_exp(c0, h, iv, m, circ, live_len);

        @(negedge clk);
        chk("start_busy", int'(busy), 1);
        chk("start_count", int'(wr_count), 0);
        chk("start_done", int'(done), 0);
        chk("start_wrapped", int'(wrapped), 0);
        // later input changes must not affect the run
        interval = TW'(iv + 3);
        max      = AW'(m + 1);
        holdoff  = HW'(h + 2);
        circular = ~circ;

        repeat (live_len - 1) @(negedge clk);
        chk("end_busy", int'(busy), 1 - exp_done);
        chk("end_done", int'(done), exp_done);
        chk("end_wrapped", int'(wrapped), exp_wrp);
        chk("end_count", int'(wr_count), exp_cnt);

        LIVE = 1'b0;
        @(negedge clk);
        chk("off_ena", int'(wr_ena), 0);
        chk("off_addr", int'(wr_addr), 0);
        chk("off_busy", int'(busy), 0);
        chk("off_done_hold", int'(done), exp_done);
        chk("off_count_hold", int'(wr_count), exp_cnt);
        chk("missing_wr", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b0;
        LIVE = 1'b0;
        interval = '0;
        max = '0;
        holdoff = '0;
        circular = 1'b0;
        #1;
        chk("rst_ena", int'(wr_ena), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(wr_count), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 4, 3, 1'b0, 20);   // one-shot basic
        run(5, 0, 2, 1'b0, 10);   // holdoff with interval 0
        run(0, 2, 3, 1'b1, 15);   // circular wrap, 7 writes
        run(0, 4, 5, 1'b0, 8);    // LIVE falls on the edge of write 2
        run(3, 3, 2, 1'b0, 6);    // fresh edge clears count; holdoff beats write
        run(0, 1, 0, 1'b0, 20);   // full depth, count saturates
        run(0, 1, 0, 1'b1, 11);   // circular, 10 writes, saturation

        // reset in the middle of a circular run
        @(negedge clk);
        holdoff = '0;
        interval = TW'(2);
        max = AW'(3);
        circular = 1'b1;
        LIVE = 1'b1;
        push_exp(cyc + 1, 0, 2, 3, 1'b1, 5);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ena", int'(wr_ena), 0);
        chk("mid_rst_addr", int'(wr_addr), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(wr_count), 0);
        chk("mid_rst_missing", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("live_high_rel_busy", int'(busy), 0);
        chk("live_high_rel_count", int'(wr_count), 0);
        LIVE = 1'b0;
        @(negedge clk);
        run(1, 2, 2, 1'b0, 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/live_sample_sequencer.md
Name: live_sample_sequencer

Overview:
- Parametrised successor of the LIVE-gated RAM write-enable generator in the monitoring path.
- Produces periodic single-cycle write strobes and addresses into a snapshot RAM while LIVE is high.
- Adds a programmable holdoff after the LIVE rising edge, one-shot and circular (wrap) modes, and status outputs (busy, done, wrapped, write count) for VME readback.

Parameters:
ADDR_W, 12, RAM address width; depth = 2^ADDR_W
TIMER_W, 17, width of interval timer and interval input
HOLD_W, 16, width of holdoff counter and holdoff input
CNT_W, 24, width of saturating total-write counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
LIVE  in  1  spill/live gate, synchronous to clk
interval  in  TIMER_W  clock cycles between writes; 0 treated as 1
max  in  ADDR_W  writes per run (one-shot) or wrap length (circular); 0 means 2^ADDR_W
holdoff  in  HOLD_W  cycles to wait after LIVE rising edge before the interval timer starts
circular  in  1  0 = one-shot, 1 = wrap and continue while LIVE is high
wr_ena  out  1  one-cycle RAM write strobe
wr_addr  out  ADDR_W  RAM write address, valid while wr_ena is high
busy  out  1  high in HOLDOFF or RUN
done  out  1  one-shot run completed; sticky until next LIVE rising edge
wrapped  out  1  circular mode wrapped at least once; sticky until next LIVE rising edge
wr_count  out  CNT_W  total writes in current or last run; saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0 and the state is IDLE.
  - The internal LIVE delay register resets to 1, so a LIVE already high at reset release does not start a run; a fresh rising edge is required.
- Rising edge: LIVE=1 and LIVE delayed = 0, sampled at clock edge E0. Effects at E0:
  - interval, max, holdoff and circular are latched; later changes are ignored until the next rising edge.
  - done, wrapped and wr_count are cleared; wr_addr is set to 0.
- States:
  - IDLE: no activity. On a rising edge, go to HOLDOFF if holdoff>0, else go to RUN with timer=0.
  - HOLDOFF: counts holdoff cycles, then enters RUN with timer=0. The RUN entry edge is E(H), where H = latched holdoff.
  - RUN: timer counts 0..I-1 (I = max(interval,1)). When timer=I-1 it reloads 0 and issues a write. Write k (k=1,2,...) is strobed in the cycle after edge E(H+I*k), with wr_addr = (k-1) mod M, where M = latched max or 2^ADDR_W if max=0.
  - DONE: entered in one-shot mode on the edge that ends write M. done=1 from that edge. Stays in DONE until LIVE falls; a new run needs a new rising edge.
- Circular mode:
  - After address M-1 the next write uses address 0, and wrapped is set on the edge issuing that write.
  - The run continues until LIVE falls; done is never set.
- wr_ena and wr_addr:
  - wr_ena is high for exactly one cycle per write; it is never high in IDLE, HOLDOFF or DONE.
  - Between writes wr_addr holds the last written address.
- wr_count increments once per write and saturates at 2^CNT_W-1. It holds its value after LIVE falls, for readback.
- LIVE low in any state, on the next edge:
  - state goes to IDLE; timer and holdoff counter are cleared; busy=0.
  - wr_ena=0 and wr_addr=0.
  - done, wrapped and wr_count hold their values.
- Simultaneous events:
  - If LIVE is sampled low on the edge where a write would issue, no write occurs; LIVE low dominates.
  - A LIVE rising edge while in DONE is not possible, since LIVE must fall first.
- Latency: first write strobe is H+I cycles after E0; there is no other pipeline delay.
- Arithmetic: timer compares against I-1 at TIMER_W bits. Address and holdoff counters are modular at their widths; none overflow, because comparisons terminate them.

Test Plan:
- One-shot basic: holdoff=0, interval=4, max=3, circular=0, LIVE rises at E0 -> wr_ena in the cycles after E4, E8, E12 with addr 0,1,2; done=1 and busy=0 from E12; wr_count=3; no further strobes while LIVE stays high.
- Holdoff plus interval 0: holdoff=5, interval=0, max=2 -> strobes after E6 and E7 with addr 0,1; busy=1 from E0 to E7.
- Circular wrap: interval=2, max=3, circular=1, LIVE high 14 cycles -> addresses 0,1,2,0,1,2,0; wrapped=1 from the 4th write; done stays 0; wr_count=7.
- LIVE abort plus collision: interval=4, max=5; LIVE drops so the edge E8 samples LIVE=0 -> only write 0 occurs; wr_addr=0, busy=0, wr_count=1 held; a new rising edge clears wr_count to 0.
- Reset: assert reset mid-RUN -> all outputs 0 immediately. Release reset with LIVE held high -> no strobes until LIVE falls and rises again.
- Full depth plus saturation: ADDR_W=4, max=0, interval=1, one-shot -> 16 writes, addr 0..15, then done. With CNT_W=3, circular, 10 writes -> wr_count saturates at 7.
